vram_arbiter: RTL and testbench

//   Shares one single-port synchronous video RAM between the pixel scan-out path and two

---
 rtl/vram_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out owns visible pixel strobes, game-logic
// requesters A/B share the remaining cycles round-robin with registered read return.
module vram_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter bit VBLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_pixel,
  input  logic              disp_active,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              disp_slot;
  logic              eligible;
  logic              gnt_a;
  logic              gnt_b;
  logic              rr_b;

  logic              vld_disp_p0;
  logic              vld_a_p0;
  logic              vld_b_p0;
  logic              vld_disp_p1;
  logic              vld_a_p1;
  logic              vld_b_p1;
  logic [DATA_W-1:0] data_disp_p1;
  logic [DATA_W-1:0] data_a_p1;
  logic [DATA_W-1:0] data_b_p1;

  // Slot decision: scan-out first, then A/B with rr_b breaking ties.
  always_comb begin
    disp_slot = clk_pixel & disp_active;
    eligible  = ~disp_slot & (~VBLANK_ONLY | vblank);
    gnt_a     = eligible & a_req & (~b_req | ~rr_b);
    gnt_b     = eligible & b_req & (~a_req | rr_b);

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_slot) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (gnt_a) begin
      mem_en    = 1'b1;
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (gnt_b) begin
      mem_en    = 1'b1;
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  assign a_gnt = gnt_a;
  assign b_gnt = gnt_b;

  // Stage p0: tag the read issued this cycle with its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_disp_p0 <= 1'b0;
      vld_a_p0    <= 1'b0;
      vld_b_p0    <= 1'b0;
      rr_b        <= 1'b0;
    end else begin
      vld_disp_p0 <= disp_slot;
      vld_a_p0    <= gnt_a & ~a_we;
      vld_b_p0    <= gnt_b & ~b_we;
      if (gnt_a) begin
        rr_b <= 1'b1;
      end else if (gnt_b) begin
        rr_b <= 1'b0;
      end
    end
  end

  // Stage p1: capture RAM data for the tagged owner; data holds between returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_disp_p1  <= 1'b0;
      vld_a_p1     <= 1'b0;
      vld_b_p1     <= 1'b0;
      data_disp_p1 <= '0;
      data_a_p1    <= '0;
      data_b_p1    <= '0;
    end else begin
      vld_disp_p1 <= vld_disp_p0;
      vld_a_p1    <= vld_a_p0;
      vld_b_p1    <= vld_b_p0;
      if (vld_disp_p0) begin
        data_disp_p1 <= mem_rdata;
      end
      if (vld_a_p0) begin
        data_a_p1 <= mem_rdata;
      end
      if (vld_b_p0) begin
        data_b_p1 <= mem_rdata;
      end
    end
  end

  assign disp_valid = vld_disp_p1;
  assign disp_data  = data_disp_p1;
  assign a_rvalid   = vld_a_p1;
  assign a_rdata    = data_a_p1;
  assign b_rvalid   = vld_b_p1;
  assign b_rdata    = data_b_p1;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: predicted grants/mem bus per cycle, queued
// read returns checked at T+2, plus a VBLANK_ONLY=1 instance for the blanking gate.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_pixel, disp_active, vblank;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] v_disp_data, v_a_rdata, v_b_rdata, v_mem_wdata;
  logic          v_disp_valid, v_a_gnt, v_a_rvalid, v_b_gnt, v_b_rvalid, v_mem_en, v_mem_we;
  logic [AW-1:0] v_mem_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int disp_cnt = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } ret_t;
  ret_t dq[$];
  ret_t aq[$];
  ret_t bq[$];

  logic [DW-1:0] ram [0:511];
  logic [DW-1:0] ref_mem [0:511];
  logic          m_rr_b;
  logic          c_slot, c_ea, c_eb;
  logic [26:0]   c_exp, c_act;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VBLANK_ONLY(1'b0)) dut (
    .clk(clk), .rst(rst), .clk_pixel(clk_pixel), .disp_active(disp_active), .vblank(vblank),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VBLANK_ONLY(1'b1)) u_vb (
    .clk(clk), .rst(rst), .clk_pixel(clk_pixel), .disp_active(disp_active), .vblank(vblank),
    .disp_addr(disp_addr), .disp_data(v_disp_data), .disp_valid(v_disp_valid),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(v_a_gnt),
    .a_rdata(v_a_rdata), .a_rvalid(v_a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(v_b_gnt),
    .b_rdata(v_b_rdata), .b_rvalid(v_b_rvalid),
    .mem_en(v_mem_en), .mem_we(v_mem_we), .mem_addr(v_mem_addr), .mem_wdata(v_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM attached to the main instance, cleared by reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
    end else begin
      if (mem_en && mem_we) ram[mem_addr[8:0]] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[8:0]];
    end
  end

  // Per-cycle prediction of grants and RAM bus; queues expected read returns
  always @(negedge clk) begin
    #2;
    if (rst) begin
      dq.delete();
      aq.delete();
      bq.delete();
      m_rr_b = 1'b0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    end else if (mon_on) begin
      c_slot = clk_pixel && disp_active;
      c_ea = 1'b0;
      c_eb = 1'b0;
      if (!c_slot) begin
        if (a_req && b_req) begin
          if (m_rr_b) c_eb = 1'b1;
          else c_ea = 1'b1;
        end else if (a_req) begin
          c_ea = 1'b1;
        end else if (b_req) begin
          c_eb = 1'b1;
        end
      end
      c_exp = '0;
      if (c_slot) c_exp = {2'b00, 1'b1, 1'b0, disp_addr, 8'h00};
      else if (c_ea) c_exp = {2'b10, 1'b1, a_we, a_addr, a_wdata};
      else if (c_eb) c_exp = {2'b01, 1'b1, b_we, b_addr, b_wdata};
      c_act = {a_gnt, b_gnt, mem_en, mem_we, mem_addr, (c_slot ? 8'h00 : mem_wdata)};
      checks++;
      if (c_act !== c_exp) begin
        errors++;
        $display("FAIL bus cyc=%0d got gnt/en/we/addr/wdata=%h expected %h", cyc, c_act, c_exp);
      end
      if (c_slot) dq.push_back('{due: cyc + 2, data: ref_mem[disp_addr[8:0]]});
      if (c_ea) begin
        if (a_we) ref_mem[a_addr[8:0]] = a_wdata;
        else aq.push_back('{due: cyc + 2, data: ref_mem[a_addr[8:0]]});
        m_rr_b = 1'b1;
      end
      if (c_eb) begin
        if (b_we) ref_mem[b_addr[8:0]] = b_wdata;
        else bq.push_back('{due: cyc + 2, data: ref_mem[b_addr[8:0]]});
        m_rr_b = 1'b0;
      end
    end
  end

  // Return-path monitor: each expected return must appear exactly in its due cycle
  always @(negedge clk) begin
    if (mon_on) begin
      if (disp_valid === 1'b1) disp_cnt++;
      checks++;
      if (dq.size() > 0 && dq[0].due == cyc) begin
        if (disp_valid !== 1'b1 || disp_data !== dq[0].data) begin
          errors++;
          $display("FAIL disp_ret cyc=%0d got v=%b d=%h expected v=1 d=%h", cyc, disp_valid, disp_data, dq[0].data);
        end
        void'(dq.pop_front());
      end else if (disp_valid !== 1'b0) begin
        errors++;
        $display("FAIL disp_spurious cyc=%0d got disp_valid=%b expected 0", cyc, disp_valid);
      end
      checks++;
      if (aq.size() > 0 && aq[0].due == cyc) begin
        if (a_rvalid !== 1'b1 || a_rdata !== aq[0].data) begin
          errors++;
          $display("FAIL a_ret cyc=%0d got v=%b d=%h expected v=1 d=%h", cyc, a_rvalid, a_rdata, aq[0].data);
        end
        void'(aq.pop_front());
      end else if (a_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL a_spurious cyc=%0d got a_rvalid=%b expected 0", cyc, a_rvalid);
      end
      checks++;
      if (bq.size() > 0 && bq[0].due == cyc) begin
        if (b_rvalid !== 1'b1 || b_rdata !== bq[0].data) begin
          errors++;
          $display("FAIL b_ret cyc=%0d got v=%b d=%h expected v=1 d=%h", cyc, b_rvalid, b_rdata, bq[0].data);
        end
        void'(bq.pop_front());
      end else if (b_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL b_spurious cyc=%0d got b_rvalid=%b expected 0", cyc, b_rvalid);
      end
    end
  end

  task automatic idle();
    clk_pixel = 0; disp_active = 0; vblank = 0; disp_addr = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic test_reset();
    logic [26:0] outs;
    @(negedge clk); rst = 0; mon_on = 1'b1;
    #1 outs = {disp_valid, a_rvalid, b_rvalid, disp_data, a_rdata, b_rdata};
    checks++;
    if (outs !== 27'h0 || mem_en !== 1'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL reset_state got outs=%h en=%b addr=%h expected all 0", outs, mem_en, mem_addr);
    end
    @(negedge clk); a_req = 1; a_we = 0; a_addr = 15'h0123;
    #1 checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL midread_gnt got %b expected 1", a_gnt); end
    @(negedge clk); a_req = 0; rst = 1;
    @(negedge clk); rst = 0;
    #1 outs = {disp_valid, a_rvalid, b_rvalid, disp_data, a_rdata, b_rdata};
    checks++;
    if (outs !== 27'h0) begin errors++; $display("FAIL midread_outs got %h expected 0", outs); end
    @(negedge clk); a_req = 1; a_we = 1; a_addr = 15'h0010; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 15'h0011; b_wdata = 8'h22;
    #1 checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL rr_after_reset got %b expected 10", {a_gnt, b_gnt}); end
    @(negedge clk); idle();
  endtask

  task automatic test_display_priority();
    @(negedge clk); idle(); b_req = 1; b_we = 1; b_addr = 15'h0123; b_wdata = 8'h5A;
    @(negedge clk); idle(); clk_pixel = 1; disp_active = 1; disp_addr = 15'h0123;
    a_req = 1; a_we = 0; a_addr = 15'h0050;
    #1 checks++;
    if (a_gnt !== 1'b0 || mem_addr !== 15'h0123 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
      errors++; $display("FAIL disp_prio got a_gnt=%b addr=%h expected a_gnt=0 addr=0123", a_gnt, mem_addr);
    end
    @(negedge clk); clk_pixel = 0; disp_active = 0;
    #1 checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL disp_then_a got %b expected 1", a_gnt); end
    @(negedge clk); a_req = 0;
    #1 checks++;
    if (disp_valid !== 1'b1 || disp_data !== 8'h5A) begin
      errors++; $display("FAIL disp_data got v=%b d=%h expected v=1 d=5a", disp_valid, disp_data);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    @(negedge clk); idle(); b_req = 1; b_we = 1; b_addr = 15'h0020; b_wdata = 8'h01;
    #1 checks++;
    if (b_gnt !== 1'b1) begin errors++; $display("FAIL rr_prime got %b expected 1", b_gnt); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      a_req = 1; a_we = 1; a_addr = 15'(33 + i); a_wdata = 8'(16 + i);
      b_req = 1; b_we = 1; b_addr = 15'(40 + i); b_wdata = 8'(48 + i);
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1 checks++;
      if ({a_gnt, b_gnt} !== exp_g) begin
        errors++; $display("FAIL rr_seq%0d got %b expected %b", i, {a_gnt, b_gnt}, exp_g);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); a_req = 1; a_we = 0; a_addr = 15'(33 + i);
      #1 checks++;
      if (a_gnt !== 1'b1) begin errors++; $display("FAIL single_a%0d got %b expected 1", i, a_gnt); end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_vblank_only();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle(); a_req = 1; a_we = 1; a_addr = 15'h0060; a_wdata = 8'h77;
      #1 checks++;
      if (v_a_gnt !== 1'b0 || v_mem_en !== 1'b0 || v_mem_addr !== '0 || v_mem_wdata !== '0) begin
        errors++; $display("FAIL vb_block%0d got gnt=%b en=%b addr=%h expected 0", i, v_a_gnt, v_mem_en, v_mem_addr);
      end
    end
    @(negedge clk); vblank = 1;
    #1 checks++;
    if (v_a_gnt !== 1'b1 || v_mem_en !== 1'b1 || v_mem_addr !== 15'h0060 || v_mem_we !== 1'b1) begin
      errors++; $display("FAIL vb_grant got gnt=%b en=%b addr=%h expected 1 1 0060", v_a_gnt, v_mem_en, v_mem_addr);
    end
    @(negedge clk); idle();
  endtask

  task automatic test_free_pixel_slot();
    @(negedge clk); idle(); clk_pixel = 1; b_req = 1; b_we = 1; b_addr = 15'h0040; b_wdata = 8'hA5;
    #1 checks++;
    if (b_gnt !== 1'b1 || mem_we !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 15'h0040) begin
      errors++; $display("FAIL free_slot got gnt=%b we=%b addr=%h expected 1 1 0040", b_gnt, mem_we, mem_addr);
    end
    @(negedge clk); idle(); b_req = 1; b_we = 0; b_addr = 15'h0040;
    #1 checks++;
    if (ram[9'h040] !== 8'hA5 || b_gnt !== 1'b1) begin
      errors++; $display("FAIL free_write got ram=%h gnt=%b expected a5 1", ram[9'h040], b_gnt);
    end
    @(negedge clk); idle();
    @(negedge clk);
    #1 checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'hA5) begin
      errors++; $display("FAIL b_readback got v=%b d=%h expected v=1 d=a5", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_frame();
    logic ga = 1'b0, gb = 1'b0;
    int a_wait = 0, b_wait = 0, max_wait = 0, pixels = 0, cnt0, bad = 0;
    cnt0 = disp_cnt;
    for (int line = 0; line < 11; line++) begin
      for (int x = 0; x < 32; x++) begin
        @(negedge clk);
        if (ga) a_req = 0;
        if (gb) b_req = 0;
        if (!a_req && $urandom_range(0, 2) == 0) begin
          a_req = 1; a_we = 1'($urandom_range(0, 1));
          a_addr = 15'($urandom_range(0, 255)); a_wdata = 8'($urandom);
        end
        if (!b_req && $urandom_range(0, 2) == 0) begin
          b_req = 1; b_we = 1'($urandom_range(0, 1));
          b_addr = 15'($urandom_range(0, 255)); b_wdata = 8'($urandom);
        end
        vblank = (line >= 8);
        clk_pixel = (x % 2 == 0);
        disp_active = (line < 8) && (x / 2 < 10);
        disp_addr = 15'($urandom_range(0, 511));
        if (clk_pixel && disp_active) pixels++;
        #1 ga = a_gnt; gb = b_gnt;
        a_wait = (a_req && !ga) ? a_wait + 1 : 0;
        b_wait = (b_req && !gb) ? b_wait + 1 : 0;
        if (a_wait > max_wait) max_wait = a_wait;
        if (b_wait > max_wait) max_wait = b_wait;
      end
    end
    clk_pixel = 0; disp_active = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ga) a_req = 0;
      if (gb) b_req = 0;
      #1 ga = a_gnt; gb = b_gnt;
      a_wait = (a_req && !ga) ? a_wait + 1 : 0;
      b_wait = (b_req && !gb) ? b_wait + 1 : 0;
      if (a_wait > max_wait) max_wait = a_wait;
      if (b_wait > max_wait) max_wait = b_wait;
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    #1 checks++;
    if (disp_cnt - cnt0 != pixels) begin
      errors++; $display("FAIL frame_disp_valid got %0d expected %0d", disp_cnt - cnt0, pixels);
    end
    checks++;
    if (max_wait > 64 || a_wait != 0 || b_wait != 0) begin
      errors++; $display("FAIL frame_starve got max_wait=%0d expected <=64 and none pending", max_wait);
    end
    for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL frame_ram got %0d differing bytes expected 0", bad); end
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) @(negedge clk);
    test_reset();
    test_display_priority();
    test_round_robin();
    test_vblank_only();
    test_free_pixel_slot();
    test_frame();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
